riscv_alu_arbiter: RTL
======================

Name: riscv_alu_arbiter

Overview:
- Shares one riscv_alu instance between two requesters, e.g. requester 0 = execute stage, requester 1 = address/branch-target helper.
- Each requester presents operands and an ALU control code under a valid/ready handshake.
- The block grants one request per cycle with round-robin fairness, drives the ALU, and registers the result into a one-entry response buffer tagged with the requester ID.
- Response consumption uses valid/ready back-pressure.

Parameters:
- CNT_W, 16, width of the per-requester saturating grant counters.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_req0_valid  input  1  requester 0 has an operation
- i_req0_a  input  `XLEN  requester 0 operand A
- i_req0_b  input  `XLEN  requester 0 operand B
- i_req0_ctrl  input  5  requester 0 ALU control code (`ALU_CTRL_* from riscv_configs.v)
- o_req0_ready  output  1  requester 0 operation accepted this cycle
- i_req1_valid, i_req1_a, i_req1_b, i_req1_ctrl, o_req1_ready  same as requester 0, for requester 1
- o_rsp_valid  output  1  response buffer holds a result
- o_rsp_id  output  1  requester that issued the buffered result
- o_rsp_result  output  `XLEN  buffered ALU result
- o_rsp_zero  output  1  buffered ALU zero flag
- i_rsp_ready  input  1  consumer takes the response this cycle
- o_grant_cnt0  output  CNT_W  saturating count of accepted requester-0 operations
- o_grant_cnt1  output  CNT_W  saturating count of accepted requester-1 operations

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer): o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_rsp_zero=0, both counters=0. Round-robin pointer last_grant=1, so requester 0 wins the first contention.
- can_accept = !o_rsp_valid | i_rsp_ready. The buffer is empty or drains this cycle, so throughput is one operation per cycle.
- Grant is combinational:
  - If !can_accept: no grant; both ready signals are 0.
  - Else if only one valid: grant that requester.
  - Else if both valid: grant the requester != last_grant.
  - Else: no grant.
- o_reqN_ready = grant to N. A ready signal never asserts for a requester whose valid is low. Requesters must hold their payload stable while valid & !ready.
- The ALU operand/control mux selects the granted requester's a/b/ctrl. With no grant it selects requester 0 (result discarded).
- On a grant (accept), at the next rising edge:
  - o_rsp_valid=1, o_rsp_id=granted ID.
  - o_rsp_result / o_rsp_zero = ALU outputs.
  - last_grant=granted ID.
  - Granted counter +1, saturating at all-ones.
- Latency from accept to o_rsp_valid is exactly 1 cycle. No combinational path exists from request inputs to the o_rsp_* outputs.
- With no grant and o_rsp_valid & i_rsp_ready: o_rsp_valid=0 next cycle. o_rsp_result, o_rsp_id and o_rsp_zero hold their last values.
- With o_rsp_valid & !i_rsp_ready: all o_rsp_* hold stable, no grant. last_grant is unchanged, so the pending winner keeps its turn.
- Simultaneous drain and accept in one cycle: the buffer is overwritten with the new result and o_rsp_valid stays 1. No bubble occurs.
- last_grant updates only on an accept. A single active requester can be granted back-to-back indefinitely.
- Control codes pass through unmodified. Result semantics for each code are those of riscv_alu. Shift amounts use b[4:0].
- Counters saturate and do not wrap. They are cleared only by reset.

Test Plan:
- Reset, then req0 only: a=5, b=3, ctrl=`ALU_CTRL_ADD -> ready0=1 same cycle. Next cycle: rsp_valid=1, id=0, result=8, zero=0, cnt0=1.
- Both valid every cycle, i_rsp_ready=1:
  - req0: SUB 7-7.
  - req1: SLT a=0xFFFFFFFF, b=1.
  - Required: grants alternate 0,1,0,1; responses id0 result=0 zero=1; id1 result=1 zero=0; no idle cycles.
- Back-pressure: hold i_rsp_ready=0 for 3 cycles with both valid -> both ready=0; rsp outputs stable. Raise ready: the held request (next round-robin winner) is granted in the same cycle; rsp_valid stays 1 across the swap.
- req1 alone for 4 cycles (SRA a=0x80000000, b=4) -> 4 consecutive grants to req1; each result=0xF8000000, id=1; cnt1=4, cnt0 unchanged.
- Reset asserted asynchronously while rsp_valid=1 and both requests pending -> o_rsp_valid and o_rsp_result drop to 0 before the next clock edge. After release, requester 0 wins the first contention.
- Counter saturation: CNT_W=2, 5 grants to req0 -> cnt0 reads 1,2,3,3,3.

Source files
------------

// File: rtl/riscv_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_alu_arbiter (with local riscv_alu)
// Description : Shares one riscv_alu between two requesters.
//               - Valid/ready request handshakes with round-robin arbitration.
//               - One operation is granted per cycle.
//               - The result is registered into a one-entry response buffer
//                 tagged with the requester ID.
//               - The response is drained through a valid/ready handshake.
// Ports       : i_clk, i_rst (async, active-high)
//               i_reqN_valid/a/b/ctrl, o_reqN_ready  (N = 0,1)
//               o_rsp_valid/id/result/zero, i_rsp_ready
//               o_grant_cnt0/1 : saturating accepted-operation counters
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALU_CTRL_ADD
`define ALU_CTRL_ADD  5'd0
`define ALU_CTRL_SUB  5'd1
`define ALU_CTRL_SLL  5'd2
`define ALU_CTRL_SLT  5'd3
`define ALU_CTRL_SLTU 5'd4
`define ALU_CTRL_XOR  5'd5
`define ALU_CTRL_SRL  5'd6
`define ALU_CTRL_SRA  5'd7
`define ALU_CTRL_OR   5'd8
`define ALU_CTRL_AND  5'd9
`endif

// Purely combinational RV32 integer ALU. Unknown control codes yield 0.
module riscv_alu (
    input  logic [`XLEN-1:0] i_a,
    input  logic [`XLEN-1:0] i_b,
    input  logic [4:0]       i_ctrl,
    output logic [`XLEN-1:0] o_result,
    output logic             o_zero
);
    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            `ALU_CTRL_ADD:  o_result = i_a + i_b;
            `ALU_CTRL_SUB:  o_result = i_a - i_b;
            `ALU_CTRL_SLL:  o_result = i_a << w_shamt;
            `ALU_CTRL_SLT:  o_result = {{(`XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            `ALU_CTRL_SLTU: o_result = {{(`XLEN-1){1'b0}}, (i_a < i_b)};
            `ALU_CTRL_XOR:  o_result = i_a ^ i_b;
            `ALU_CTRL_SRL:  o_result = i_a >> w_shamt;
            `ALU_CTRL_SRA:  o_result = $signed(i_a) >>> w_shamt;
            `ALU_CTRL_OR:   o_result = i_a | i_b;
            `ALU_CTRL_AND:  o_result = i_a & i_b;
            default:        o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);
endmodule

module riscv_alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic [`XLEN-1:0] i_req0_a,
    input  logic [`XLEN-1:0] i_req0_b,
    input  logic [4:0]       i_req0_ctrl,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [`XLEN-1:0] i_req1_a,
    input  logic [`XLEN-1:0] i_req1_b,
    input  logic [4:0]       i_req1_ctrl,
    output logic             o_req1_ready,
    output logic             o_rsp_valid,
    output logic             o_rsp_id,
    output logic [`XLEN-1:0] o_rsp_result,
    output logic             o_rsp_zero,
    input  logic             i_rsp_ready,
    output logic [CNT_W-1:0] o_grant_cnt0,
    output logic [CNT_W-1:0] o_grant_cnt1
);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [`XLEN-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_can_accept;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic [`XLEN-1:0] w_alu_a;
    logic [`XLEN-1:0] w_alu_b;
    logic [4:0]       w_alu_ctrl;
    logic [`XLEN-1:0] w_alu_result;
    logic             w_alu_zero;

    // Buffer is free, or its content leaves this cycle: accept without a bubble.
    assign w_can_accept = !r_rsp_valid || i_rsp_ready;

    // Under contention the requester that did not win last time goes first.
    // last_grant only moves on an accept, so a stalled winner keeps its turn.
    assign w_gnt0   = w_can_accept && i_req0_valid && (!i_req1_valid || r_last_grant);
    assign w_gnt1   = w_can_accept && i_req1_valid && (!i_req0_valid || !r_last_grant);
    assign w_accept = w_gnt0 || w_gnt1;

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;

    // Requester 0 is the default mux leg; its result is discarded without a grant.
    assign w_alu_a    = w_gnt1 ? i_req1_a    : i_req0_a;
    assign w_alu_b    = w_gnt1 ? i_req1_b    : i_req0_b;
    assign w_alu_ctrl = w_gnt1 ? i_req1_ctrl : i_req0_ctrl;

    riscv_alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_ctrl   (w_alu_ctrl),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            if (w_accept) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= w_gnt1;
                r_rsp_result <= w_alu_result;
                r_rsp_zero   <= w_alu_zero;
                r_last_grant <= w_gnt1;
            end else if (i_rsp_ready) begin
                // Drain without refill: payload fields keep their last value.
                r_rsp_valid <= 1'b0;
            end
            if (w_gnt0 && (r_cnt0 != c_cnt_max)) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_gnt1 && (r_cnt1 != c_cnt_max)) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_zero   = r_rsp_zero;
    assign o_grant_cnt0 = r_cnt0;
    assign o_grant_cnt1 = r_cnt1;
endmodule
`default_nettype wire
